// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : shared widths, ALU opcodes and arbiter FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int IMM_W  = 5;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SLL = 4'b0010;
  localparam logic [OP_W-1:0] OP_SRL = 4'b0011;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLT = 4'b0101;
  localparam logic [OP_W-1:0] OP_ABS = 4'b0110;
  localparam logic [OP_W-1:0] OP_SEQ = 4'b0111;
  localparam logic [OP_W-1:0] OP_SET = 4'b1000;
  localparam logic [OP_W-1:0] OP_NOP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Only the compare ops produce a meaningful CB flag.
  function automatic logic is_flag_op(input logic [OP_W-1:0] op);
    return (op == OP_SLT) || (op == OP_SEQ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : combinational two-way round-robin grant (one-hot)
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  // On contention the requester that did not win last time is favoured.
  assign o_grant[0] = i_valid[0] & (~i_valid[1] |  i_last_grant);
  assign o_grant[1] = i_valid[1] & (~i_valid[0] | ~i_last_grant);

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : shares one combinational ALU between two requesters with a
//               round-robin grant and a back-pressured tagged response.
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_pkg::*;
#(
  parameter logic [OP_W-1:0] MAX_OP = OP_SET
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [OP_W-1:0]   req0_opcode_i,
  input  logic [DATA_W-1:0] req0_rs_i,
  input  logic [DATA_W-1:0] req0_rt_i,
  input  logic [IMM_W-1:0]  req0_imm_i,

  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [OP_W-1:0]   req1_opcode_i,
  input  logic [DATA_W-1:0] req1_rs_i,
  input  logic [DATA_W-1:0] req1_rt_i,
  input  logic [IMM_W-1:0]  req1_imm_i,

  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_cb_o,
  output logic              rsp_err_o,

  output logic [OP_W-1:0]   alu_opcode_o,
  output logic [DATA_W-1:0] alu_rs_o,
  output logic [DATA_W-1:0] alu_rt_o,
  output logic [IMM_W-1:0]  alu_imm_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i
);

  state_t          r_state;
  logic            r_last_grant;
  logic            r_id;
  logic [OP_W-1:0] r_op;
  logic            r_illegal;

  logic [1:0]        w_grant;
  logic [1:0]        w_take;
  logic              w_accept;
  logic              w_sel;
  logic [OP_W-1:0]   w_op;
  logic [DATA_W-1:0] w_rs;
  logic [DATA_W-1:0] w_rt;
  logic [IMM_W-1:0]  w_imm;
  logic              w_illegal;

  rr_arbiter2 u_rr (
    .i_valid      ({req1_valid_i, req0_valid_i}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Ready is offered only while idle; reset suppresses it in the same cycle.
  assign w_take       = w_grant & {2{(r_state == ST_IDLE) && !reset}};
  assign req0_ready_o = w_take[0];
  assign req1_ready_o = w_take[1];
  assign w_accept     = |w_take;
  assign w_sel        = w_take[1];

  assign w_op      = w_sel ? req1_opcode_i : req0_opcode_i;
  assign w_rs      = w_sel ? req1_rs_i     : req0_rs_i;
  assign w_rt      = w_sel ? req1_rt_i     : req0_rt_i;
  assign w_imm     = w_sel ? req1_imm_i    : req0_imm_i;
  assign w_illegal = (w_op > MAX_OP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_op         <= OP_NOP;
      r_illegal    <= 1'b0;
      alu_opcode_o <= OP_NOP;
      alu_rs_o     <= '0;
      alu_rt_o     <= '0;
      alu_imm_o    <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= 1'b0;
      rsp_result_o <= '0;
      rsp_cb_o     <= 1'b0;
      rsp_err_o    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id         <= w_sel;
            r_last_grant <= w_sel;
            r_op         <= w_op;
            r_illegal    <= w_illegal;
            // An illegal op drives NOP so the ALU keeps its internal state.
            alu_opcode_o <= w_illegal ? OP_NOP : w_op;
            alu_rs_o     <= w_rs;
            alu_rt_o     <= w_rt;
            alu_imm_o    <= w_imm;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_id_o     <= r_id;
          rsp_err_o    <= r_illegal;
          rsp_result_o <= r_illegal ? '0 : alu_result_i;
          rsp_cb_o     <= !r_illegal && is_flag_op(r_op) && alu_zero_i;
          rsp_valid_o  <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : randomized and directed bench with a transaction-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic       req0_ready_o, req1_ready_o;
  logic [3:0] req0_opcode_i = '0, req1_opcode_i = '0;
  logic [7:0] req0_rs_i = '0, req0_rt_i = '0, req1_rs_i = '0, req1_rt_i = '0;
  logic [4:0] req0_imm_i = '0, req1_imm_i = '0;
  logic       rsp_valid_o, rsp_ready_i = 1'b1, rsp_id_o, rsp_cb_o, rsp_err_o;
  logic [7:0] rsp_result_o;
  logic [3:0] alu_opcode_o;
  logic [7:0] alu_rs_o, alu_rt_o, alu_result_i;
  logic [4:0] alu_imm_o;
  logic       alu_zero_i;

  int n_cmp = 0;
  int n_fail = 0;
  bit done = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_opcode_i(req0_opcode_i),
    .req0_rs_i(req0_rs_i), .req0_rt_i(req0_rt_i), .req0_imm_i(req0_imm_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_opcode_i(req1_opcode_i),
    .req1_rs_i(req1_rs_i), .req1_rt_i(req1_rt_i), .req1_imm_i(req1_imm_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_result_o(rsp_result_o), .rsp_cb_o(rsp_cb_o), .rsp_err_o(rsp_err_o),
    .alu_opcode_o(alu_opcode_o), .alu_rs_o(alu_rs_o), .alu_rt_o(alu_rt_o),
    .alu_imm_o(alu_imm_o), .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i)
  );

  // Behavioural ALU sitting behind the arbiter.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [4:0] imm);
    case (op)
      4'h0: return a & b;
      4'h1: return a + b;
      4'h2: return a << imm[2:0];
      4'h3: return a >> imm[2:0];
      4'h4: return a - b;
      4'h5: return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      4'h6: return a[7] ? (8'd0 - a) : a;
      4'h7: return (a == b) ? 8'd1 : 8'd0;
      4'h8: return {3'b000, imm};
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic alu_z(input logic [3:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic [4:0] imm);
    case (op)
      4'h5: return $signed(a) < $signed(b);
      4'h7: return a == b;
      default: return alu_f(op, a, b, imm) == 8'd0;
    endcase
  endfunction

  assign alu_result_i = alu_f(alu_opcode_o, alu_rs_o, alu_rt_o, alu_imm_o);
  assign alu_zero_i   = alu_z(alu_opcode_o, alu_rs_o, alu_rt_o, alu_imm_o);

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Transaction-level model: one op in flight, response two cycles after accept.
  int         cyc = 0;
  int         m_acc = 0;
  logic       m_pend = 1'b0, m_last = 1'b1, m_id = 1'b0;
  logic [7:0] m_res = '0;
  logic       m_cb = 1'b0, m_err = 1'b0;
  logic [3:0] m_aop = 4'hF;
  logic [7:0] m_ars = '0, m_art = '0;
  logic [4:0] m_aimm = '0;

  always @(negedge clk) begin
    logic       g0, g1, erv, sel, ill;
    logic [3:0] op;
    logic [7:0] rs, rt;
    logic [4:0] imm;
    if (!done) begin
      cyc++;
      g0 = 1'b0;
      g1 = 1'b0;
      if (!reset && !m_pend) begin
        if (req0_valid_i && req1_valid_i) begin
          g0 = m_last;
          g1 = !m_last;
        end else begin
          g0 = req0_valid_i;
          g1 = req1_valid_i;
        end
      end
      erv = m_pend && (cyc >= m_acc + 2);
      chk("m_ready0", req0_ready_o, g0);
      chk("m_ready1", req1_ready_o, g1);
      chk("m_rsp_valid", rsp_valid_o, erv);
      chk("m_alu_op", alu_opcode_o, m_aop);
      chk("m_alu_rs", alu_rs_o, m_ars);
      chk("m_alu_rt", alu_rt_o, m_art);
      chk("m_alu_imm", alu_imm_o, m_aimm);
      if (erv) begin
        chk("m_rsp_id", rsp_id_o, m_id);
        chk("m_rsp_result", rsp_result_o, m_res);
        chk("m_rsp_cb", rsp_cb_o, m_cb);
        chk("m_rsp_err", rsp_err_o, m_err);
      end
      if (reset) begin
        m_pend = 1'b0; m_last = 1'b1;
        m_aop = 4'hF; m_ars = '0; m_art = '0; m_aimm = '0;
      end else if (g0 || g1) begin
        sel = g1;
        op  = sel ? req1_opcode_i : req0_opcode_i;
        rs  = sel ? req1_rs_i : req0_rs_i;
        rt  = sel ? req1_rt_i : req0_rt_i;
        imm = sel ? req1_imm_i : req0_imm_i;
        ill = op > 4'd8;
        m_pend = 1'b1; m_acc = cyc; m_last = sel; m_id = sel;
        m_aop = ill ? 4'hF : op; m_ars = rs; m_art = rt; m_aimm = imm;
        m_err = ill;
        m_res = ill ? 8'd0 : alu_f(op, rs, rt, imm);
        m_cb  = !ill && (op == 4'h5 || op == 4'h7) && alu_z(op, rs, rt, imm);
      end else if (erv && rsp_ready_i) begin
        m_pend = 1'b0;
      end
    end
  end

  task automatic drive(input bit id, input logic v, input logic [3:0] op,
                       input logic [7:0] rs, input logic [7:0] rt, input logic [4:0] imm);
    if (id) begin
      req1_valid_i = v; req1_opcode_i = op; req1_rs_i = rs; req1_rt_i = rt; req1_imm_i = imm;
    end else begin
      req0_valid_i = v; req0_opcode_i = op; req0_rs_i = rs; req0_rt_i = rt; req0_imm_i = imm;
    end
  endtask

  task automatic drive_rand(input bit id, input logic v);
    drive(id, v, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
          8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)));
  endtask

  task automatic wait_ready(input bit id, input string nm);
    bit got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (id ? req1_ready_o : req0_ready_o) begin
        got = 1;
        break;
      end
    end
    chk(nm, got, 1);
  endtask

  task automatic do_op(input bit id, input logic [3:0] op, input logic [7:0] rs,
                       input logic [7:0] rt, input logic [4:0] imm, input logic [3:0] e_aop,
                       input logic [7:0] e_res, input logic e_cb, input logic e_err);
    @(posedge clk); #1;
    drive(id, 1'b1, op, rs, rt, imm);
    wait_ready(id, "op_grant");
    @(posedge clk); #1;
    drive(id, 1'b0, op, rs, rt, imm);
    @(negedge clk);
    chk("op_exec_aluop", alu_opcode_o, e_aop);
    chk("op_exec_valid", rsp_valid_o, 0);
    @(negedge clk);
    chk("op_rsp_valid", rsp_valid_o, 1);
    chk("op_rsp_id", rsp_id_o, id);
    chk("op_rsp_result", rsp_result_o, e_res);
    chk("op_rsp_cb", rsp_cb_o, e_cb);
    chk("op_rsp_err", rsp_err_o, e_err);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!rsp_valid_o) break;
    end
  endtask

  initial begin
    int   seq[8];
    int   nacc, c0, c1;
    logic acc0, acc1;
    logic [7:0] cap_res;
    logic cap_id, cap_cb;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_id", rsp_id_o, 0);
    chk("rst_rsp_result", rsp_result_o, 0);
    chk("rst_rsp_cb", rsp_cb_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_alu_op", alu_opcode_o, 4'hF);
    chk("rst_alu_rs", alu_rs_o, 0);
    chk("rst_alu_imm", alu_imm_o, 0);
    chk("rst_ready0", req0_ready_o, 0);

    do_op(1'b0, OP_ADD, 8'h05, 8'h03, 5'd0, 4'h1, 8'h08, 1'b0, 1'b0);
    do_op(1'b1, OP_SLT, 8'h02, 8'h07, 5'd0, 4'h5, 8'h01, 1'b1, 1'b0);
    do_op(1'b1, OP_SEQ, 8'h3C, 8'h3C, 5'd0, 4'h7, 8'h01, 1'b1, 1'b0);
    do_op(1'b1, OP_AND, 8'hF0, 8'h3C, 5'd0, 4'h0, 8'h30, 1'b0, 1'b0);
    do_op(1'b0, 4'hA,   8'h12, 8'h34, 5'd3, 4'hF, 8'h00, 1'b0, 1'b1);

    // Back-pressure with requester 1 waiting.
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    drive(1'b0, 1'b1, OP_SUB, 8'h09, 8'h04, 5'd0);
    wait_ready(1'b0, "bp_grant");
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_SUB, 8'h09, 8'h04, 5'd0);
    drive(1'b1, 1'b1, OP_ADD, 8'h11, 8'h22, 5'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid_o) break;
    end
    chk("bp_result", rsp_result_o, 8'h05);
    cap_res = rsp_result_o; cap_id = rsp_id_o; cap_cb = rsp_cb_o;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid_o, 1);
      chk("bp_hold_result", rsp_result_o, cap_res);
      chk("bp_hold_id", rsp_id_o, cap_id);
      chk("bp_hold_cb", rsp_cb_o, cap_cb);
      chk("bp_ready1_low", req1_ready_o, 0);
    end
    @(posedge clk); #1 rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_ready1_resp", req1_ready_o, 0);
    @(negedge clk);
    chk("bp_next_grant", req1_ready_o, 1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, OP_ADD, 8'h11, 8'h22, 5'd0);
    repeat (4) @(negedge clk);

    // Contention: both continuously valid.
    nacc = 0; c0 = 0; c1 = 0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, OP_ADD, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 5'd0);
    drive(1'b1, 1'b1, OP_SUB, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 5'd0);
    for (int k = 0; k < 60 && nacc < 8; k++) begin
      @(negedge clk);
      acc0 = req0_ready_o;
      acc1 = req1_ready_o;
      if (acc0) begin seq[nacc] = 0; nacc++; c0++; end
      else if (acc1) begin seq[nacc] = 1; nacc++; c1++; end
      @(posedge clk); #1;
      if (acc0) drive(1'b0, 1'b1, OP_ADD, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 5'd0);
      if (acc1) drive(1'b1, 1'b1, OP_SUB, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 5'd0);
    end
    drive(1'b0, 1'b0, OP_AND, 8'd0, 8'd0, 5'd0);
    drive(1'b1, 1'b0, OP_AND, 8'd0, 8'd0, 5'd0);
    chk("cont_ops", nacc, 8);
    chk("cont_grants0", c0, 4);
    chk("cont_grants1", c1, 4);
    for (int k = 1; k < 8; k++) chk("cont_alternate", seq[k] != seq[k-1], 1);
    repeat (4) @(negedge clk);

    // Reset while the op is in EXEC.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, OP_ADD, 8'h01, 8'h02, 5'd0);
    wait_ready(1'b1, "rstmid_grant");
    @(posedge clk); #1;
    drive(1'b1, 1'b0, OP_ADD, 8'h01, 8'h02, 5'd0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", rsp_valid_o, 0);
    chk("rstmid_ready0", req0_ready_o, 0);
    chk("rstmid_ready1", req1_ready_o, 0);
    chk("rstmid_aluop", alu_opcode_o, 4'hF);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, OP_SET, 8'h00, 8'h00, 5'd7);
    drive(1'b1, 1'b1, OP_SET, 8'h00, 8'h00, 5'd9);
    @(negedge clk);
    chk("rstmid_first0", req0_ready_o, 1);
    chk("rstmid_first1", req1_ready_o, 0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_SET, 8'h00, 8'h00, 5'd7);
    drive(1'b1, 1'b0, OP_SET, 8'h00, 8'h00, 5'd9);
    repeat (4) @(negedge clk);

    // Randomized traffic with back-pressure and occasional reset.
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      acc0 = req0_ready_o & req0_valid_i;
      acc1 = req1_ready_o & req1_valid_i;
      @(posedge clk); #1;
      rsp_ready_i = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 99) == 0);
      if (acc0 || !req0_valid_i) drive_rand(1'b0, 1'($urandom_range(0, 1)));
      if (acc1 || !req1_valid_i) drive_rand(1'b1, 1'($urandom_range(0, 1)));
    end
    reset = 1'b0;
    rsp_ready_i = 1'b1;
    drive(1'b0, 1'b0, OP_AND, 8'd0, 8'd0, 5'd0);
    drive(1'b1, 1'b0, OP_AND, 8'd0, 8'd0, 5'd0);
    repeat (6) @(negedge clk);

    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
